// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scanner: BLANK/DRIVE per digit, new words committed at frame start.
// Outputs registered one cycle from FSM state; load_ready drops while a word waits for the next commit.
module seg7_scan_ctrl #(
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic        lz_blank,
    output logic        load_ready,
    output logic [3:0]  value,
    output logic [3:0]  digit_en,
    output logic        dp,
    output logic        frame_start
);

    localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_CYCLES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;

    logic          pending;
    logic [15:0]   pend_data;
    logic [3:0]    pend_dp;
    logic [15:0]   disp_data;
    logic [3:0]    disp_dp;

    logic          commit_slot;
    logic          commit_now;
    logic          accept;
    logic          suppress;
    logic [3:0]    cur_nibble;

    assign commit_slot = (state == BLANK) && (idx == 2'd0) && (cnt == '0);
    // Disabled scanning lets a pending word through immediately so the display tracks loads.
    assign commit_now  = pending && (!enable || commit_slot);
    assign accept      = load_valid && !pending;
    assign load_ready  = !pending;

    // The pulse must coincide with the commit cycle itself, so it is decoded from the
    // state registers; rst_n gating keeps it low while reset is held.
    assign frame_start = rst_n && enable && commit_slot;

    assign cur_nibble = disp_data[{idx, 2'b00} +: 4];

    always_comb begin
        suppress = 1'b0;
        if (lz_blank) begin
            case (idx)
                2'd3:    suppress = (disp_data[15:12] == 4'h0);
                2'd2:    suppress = (disp_data[15:8]  == 8'h00);
                2'd1:    suppress = (disp_data[15:4]  == 12'h000);
                default: suppress = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            pend_data <= 16'h0000;
            pend_dp   <= 4'h0;
            disp_data <= 16'h0000;
            disp_dp   <= 4'h0;
        end else if (commit_now) begin
            disp_data <= pend_data;
            disp_dp   <= pend_dp;
            pending   <= 1'b0;
        end else if (accept) begin
            pend_data <= load_data;
            pend_dp   <= load_dp;
            pending   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BLANK;
            cnt      <= '0;
            idx      <= 2'd0;
            digit_en <= 4'h0;
            value    <= 4'h0;
            dp       <= 1'b0;
        end else if (!enable) begin
            state    <= BLANK;
            cnt      <= '0;
            idx      <= 2'd0;
            digit_en <= 4'h0;
        end else begin
            case (state)
                BLANK: begin
                    // Last blank cycle: latch the upcoming digit so it is stable for the whole slot.
                    if (cnt == BLANK_LAST) begin
                        state    <= DRIVE;
                        cnt      <= '0;
                        value    <= cur_nibble;
                        dp       <= !suppress && disp_dp[idx];
                        digit_en <= suppress ? 4'h0 : (4'b0001 << idx);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state    <= BLANK;
                        cnt      <= '0;
                        idx      <= idx + 1'b1;
                        digit_en <= 4'h0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= BLANK;
                    cnt      <= '0;
                    digit_en <= 4'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGIT_CYCLES=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic        lz_blank;
    logic        load_ready;
    logic [3:0]  value;
    logic [3:0]  digit_en;
    logic        dp;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_ctrl #(
        .DIGIT_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .lz_blank   (lz_blank),
        .load_ready (load_ready),
        .value      (value),
        .digit_en   (digit_en),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_commit();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        chk("commit_seen", 16'(frame_start), 16'd1);
    endtask

    // Starts on the commit cycle; walks one full 24-cycle frame and ends on the next commit cycle.
    task automatic check_frame(input logic [3:0] lit, input logic [15:0] vals, input logic [3:0] dps);
        int s;
        int p;
        for (int k = 0; k < 24; k++) begin
            s = k / 6;
            p = k % 6;
            chk("frame_start", 16'(frame_start), 16'(k == 0));
            if (p < 2) begin
                chk("blank_digit_en", 16'(digit_en), 16'h0);
            end else begin
                chk("digit_en", 16'(digit_en), lit[s] ? 16'(4'b0001 << s) : 16'h0);
                if (lit[s])
                    chk("value", 16'(value), 16'(vals[4*s +: 4]));
                chk("dp", 16'(dp), 16'(dps[s]));
            end
            @(negedge clk);
        end
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_dp    = p;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        load_valid = 1'b0;
        load_data  = 16'h0;
        load_dp    = 4'h0;
        lz_blank   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_digit_en", 16'(digit_en), 16'h0);
        chk("rst_value", 16'(value), 16'h0);
        chk("rst_dp", 16'(dp), 16'h0);
        chk("rst_frame_start", 16'(frame_start), 16'h0);
        chk("rst_load_ready", 16'(load_ready), 16'h1);

        // First cycle after release is a commit cycle
        rst_n = 1'b1;
        #1;
        chk("rel_commit", 16'(frame_start), 16'h1);

        // Basic scan of 0x1234, dp on digit 0
        load_word(16'h1234, 4'b0001);
        chk("pend_ready", 16'(load_ready), 16'h0);
        wait_commit();
        check_frame(4'b1111, 16'h1234, 4'b0001);

        // Back-pressure: 0xAAAA pending, 0xBBBB held until after the commit
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'hAAAA;
        load_dp    = 4'h0;
        @(negedge clk);
        load_data  = 16'hBBBB;
        chk("bp_ready_low", 16'(load_ready), 16'h0);
        repeat (10) @(negedge clk);
        chk("bp_ready_still_low", 16'(load_ready), 16'h0);
        wait_commit();
        chk("bp_ready_commit", 16'(load_ready), 16'h0);
        @(negedge clk);
        chk("bp_ready_after", 16'(load_ready), 16'h1);
        @(negedge clk);
        load_valid = 1'b0;
        chk("bp_bbbb_taken", 16'(load_ready), 16'h0);
        chk("bp_aaaa_en", 16'(digit_en), 16'h1);
        chk("bp_aaaa_val", 16'(value), 16'hA);
        wait_commit();
        check_frame(4'b1111, 16'hBBBB, 4'b0000);

        // Leading-zero suppression
        @(negedge clk);
        lz_blank = 1'b1;
        load_word(16'h0050, 4'b1111);
        wait_commit();
        check_frame(4'b0011, 16'h0050, 4'b0011);
        load_word(16'h0000, 4'b0000);
        wait_commit();
        check_frame(4'b0001, 16'h0000, 4'b0000);
        load_word(16'h1000, 4'b0000);
        wait_commit();
        check_frame(4'b1111, 16'h1000, 4'b0000);

        // Disable mid-DRIVE of digit 2, load while disabled, re-enable
        repeat (15) @(negedge clk);
        chk("en_mid_drive2", 16'(digit_en), 16'h4);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_digit_en", 16'(digit_en), 16'h0);
        chk("dis_fs0", 16'(frame_start), 16'h0);
        load_valid = 1'b1;
        load_data  = 16'h1357;
        load_dp    = 4'h0;
        @(negedge clk);
        load_valid = 1'b0;
        chk("dis_pending", 16'(load_ready), 16'h0);
        chk("dis_fs1", 16'(frame_start), 16'h0);
        @(negedge clk);
        chk("dis_commit_now", 16'(load_ready), 16'h1);
        chk("dis_fs2", 16'(frame_start), 16'h0);
        chk("dis_digit_en2", 16'(digit_en), 16'h0);
        enable = 1'b1;
        #1;
        chk("reen_fs", 16'(frame_start), 16'h1);
        chk("reen_off0", 16'(digit_en), 16'h0);
        @(negedge clk);
        chk("reen_fs_drop", 16'(frame_start), 16'h0);
        chk("reen_off1", 16'(digit_en), 16'h0);
        @(negedge clk);
        chk("reen_digit0", 16'(digit_en), 16'h1);
        chk("reen_value", 16'(value), 16'h7);

        // Reset mid-DRIVE with a pending load
        load_word(16'h2468, 4'b1111);
        chk("rst2_pending", 16'(load_ready), 16'h0);
        chk("rst2_driving", 16'(digit_en), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_digit_en", 16'(digit_en), 16'h0);
        chk("rst2_value", 16'(value), 16'h0);
        chk("rst2_dp", 16'(dp), 16'h0);
        chk("rst2_fs", 16'(frame_start), 16'h0);
        chk("rst2_ready", 16'(load_ready), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst2_rel_commit", 16'(frame_start), 16'h1);
        @(negedge clk);
        @(negedge clk);
        chk("rst2_digit0", 16'(digit_en), 16'h1);
        chk("rst2_value0", 16'(value), 16'h0);
        chk("rst2_dp0", 16'(dp), 16'h0);
        chk("rst2_ready_after", 16'(load_ready), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_CYCLES, default 1000: clock cycles each digit is driven; legal range >= 1.
REQ-002 SHALL have parameter BLANK_CYCLES, default 8: all-off cycles before each digit slot; legal range >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: scanning enable.
REQ-006 SHALL have port load_valid, input, 1 bit: a new display word is offered.
REQ-007 SHALL have port load_data, input, 16 bits: nibble i ([4i+3:4i]) is digit i; digit 0 is rightmost.
REQ-008 SHALL have port load_dp, input, 4 bits: bit i is the decimal point for digit i.
REQ-009 SHALL have port lz_blank, input, 1 bit: leading-zero suppression enable.
REQ-010 SHALL have port load_ready, output, 1 bit: the block can accept a load.
REQ-011 SHALL have port value, output, 4 bits: hex nibble for the external 7-segment decoder.
REQ-012 SHALL have port digit_en, output, 4 bits: one-hot active-high digit enable.
REQ-013 SHALL have port dp, output, 1 bit: decimal point for the active digit.
REQ-014 SHALL have port frame_start, output, 1 bit: single-cycle pulse at each frame commit.

Function
REQ-015 SHALL accept a load on a cycle with load_valid && load_ready, capturing load_data/load_dp into a pending register and setting pending.
REQ-016 SHALL drive load_ready = !pending; a held load_valid with load_ready low SHALL NOT be captured.
REQ-017 SHALL run a two-state FSM: BLANK and DRIVE, with slot counter cnt and digit index idx in 0..3.
REQ-018 BLANK SHALL last BLANK_CYCLES cycles with digit_en = 0, then enter DRIVE with cnt = 0.
REQ-019 DRIVE SHALL last DIGIT_CYCLES cycles with digit_en = one-hot(idx), unless the digit is suppressed under REQ-022.
REQ-020 At the end of DRIVE, the block SHALL set idx = (idx+1) mod 4 and enter BLANK; the frame period SHALL be 4*(BLANK_CYCLES+DIGIT_CYCLES) cycles.
REQ-021 Commit rule:
- Commit cycle = state BLANK, idx = 0, cnt = 0, enable = 1.
- On a commit cycle, the block SHALL pulse frame_start for one cycle.
- If pending is set on a commit cycle, the block SHALL copy the pending register into the display register and clear pending.
REQ-022 With lz_blank = 1:
- Digit i (i = 3..1) SHALL be suppressed when its nibble and all higher nibbles of the display register are 0.
- A suppressed digit SHALL keep digit_en = 0 and dp = 0 for its whole slot.
- Digit 0 SHALL never be suppressed.
REQ-023 value and dp SHALL be registered and loaded from the display register for the upcoming idx on the last BLANK cycle, so both are stable for the whole DRIVE slot; they SHALL hold during BLANK.
REQ-024 A load accepted on a commit cycle when pending was clear SHALL set pending and wait for the next commit.
REQ-025 While enable = 0:
- Next cycle, the block SHALL force state BLANK, idx = 0, cnt = 0 and digit_en = 0.
- frame_start SHALL stay 0.
- If pending is set, the block SHALL commit immediately, every cycle.
- The load handshake SHALL continue to operate.
REQ-026 When enable rises, the block SHALL start with a full BLANK for idx 0, and that BLANK's first cycle SHALL be a commit cycle.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously force:
- digit_en = 0, value = 0, dp = 0, frame_start = 0, load_ready = 1;
- state BLANK, idx = 0, cnt = 0;
- pending = 0, display and pending registers = 0.
REQ-028 Reset asserted mid-DRIVE SHALL blank the display within the same cycle; an uncommitted pending load SHALL be lost.
REQ-029 After rst_n rises with enable = 1, the first cycle SHALL be a commit cycle.

Verification (DIGIT_CYCLES = 4, BLANK_CYCLES = 2, enable = 1 unless stated)
REQ-030 Load 0x1234, dp = 0001, lz_blank = 0, then wait for a commit:
- Response, in order: 2 off cycles, then digit_en = 0001 with value = 4 and dp = 1 for 4 cycles.
- Then 2 off cycles, then 0010/3, then 0100/2, then 1000/1, all with dp = 0.
- frame_start SHALL pulse every 24 cycles.
REQ-031 Back-pressure: load 0xAAAA, then hold load_valid with 0xBBBB:
- load_ready SHALL stay low until the commit cycle.
- 0xBBBB SHALL be accepted on the cycle after the commit and displayed one frame later.
REQ-032 Leading-zero blanking: lz_blank = 1.
- Load 0x0050: digit 3 and digit 2 slots SHALL have digit_en = 0; digit 1 SHALL show 5; digit 0 SHALL show 0.
- Load 0x0000: only digit 0 SHALL be lit.
- Load 0x1000: all four digits SHALL be lit.
REQ-033 enable low mid-DRIVE of idx 2:
- digit_en SHALL be 0 on the next cycle; frame_start SHALL stay 0 while disabled.
- On re-enable: frame_start pulse, 2 off cycles, then digit_en = 0001.
REQ-034 rst_n low mid-DRIVE with a pending load:
- All outputs SHALL be 0 and load_ready = 1 immediately.
- After release, digit 0 SHALL show value 0 (display cleared, pending discarded).
